// File: rtl/call_request_unit_if.sv
// Handshake bundle between the call request unit and the elevator controller.
// master = controller/button side, slave = call_request_unit.
interface call_request_unit_if #(
  parameter int FLOORS  = 4,
  parameter int FLOOR_W = 2
);

  logic [FLOORS-1:0]  btn_raw;
  logic [FLOOR_W-1:0] cur_floor;
  logic               svc_valid;
  logic [FLOOR_W-1:0] svc_floor;
  logic [FLOORS-1:0]  pending;
  logic               req_up;
  logic               req_down;
  logic               req_here;
  logic               req_any;

  modport master (
    output btn_raw,
    output cur_floor,
    output svc_valid,
    output svc_floor,
    input  pending,
    input  req_up,
    input  req_down,
    input  req_here,
    input  req_any
  );

  modport slave (
    input  btn_raw,
    input  cur_floor,
    input  svc_valid,
    input  svc_floor,
    output pending,
    output req_up,
    output req_down,
    output req_here,
    output req_any
  );

endinterface

// File: rtl/call_request_unit.sv
// Elevator call request unit: synchronize, debounce and latch per-floor calls and
// summarize them relative to the cabin. Define CALL_CANCEL_EN to let a re-press cancel a call.
module call_request_unit #(
  parameter int FLOORS          = 4,
  parameter int FLOOR_W         = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  call_request_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [FLOORS-1:0] sync1_q;
  logic [FLOORS-1:0] sync2_q;
  logic [FLOORS-1:0] stable_q,  stable_d;
  logic [FLOORS-1:0] stable_prev_q;
  logic [FLOORS-1:0] press_q;
  logic [CNT_W-1:0]  cnt_q [FLOORS];
  logic [CNT_W-1:0]  cnt_d [FLOORS];
  logic [FLOORS-1:0] svc_hit;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic              req_up_q,   req_up_d;
  logic              req_down_q, req_down_d;
  logic              req_here_q, req_here_d;
  logic              req_any_q,  req_any_d;

  // Debounce: a level change must persist DEBOUNCE_CYCLES cycles at sync2 to be accepted.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    stable_d = stable_q;
    for (int i = 0; i < FLOORS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Service clears win over a press in the same cycle; out-of-range floors match nothing.
  always_comb begin
    svc_hit   = '0;
    pending_d = pending_q;
    for (int i = 0; i < FLOORS; i++) begin
      svc_hit[i] = bus.svc_valid && (bus.svc_floor == FLOOR_W'(i));
      if (svc_hit[i]) begin
        pending_d[i] = 1'b0;
      end else if (press_q[i]) begin
`ifdef CALL_CANCEL_EN
        pending_d[i] = ~pending_q[i];
`else
        pending_d[i] = 1'b1;
`endif
      end
    end
  end

  // Floors past the top compare below any cur_floor >= FLOORS, so req_down then equals req_any.
  always_comb begin
    req_up_d   = 1'b0;
    req_down_d = 1'b0;
    req_here_d = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending_q[i]) begin
        if (FLOOR_W'(i) > bus.cur_floor)  req_up_d   = 1'b1;
        if (FLOOR_W'(i) < bus.cur_floor)  req_down_d = 1'b1;
        if (FLOOR_W'(i) == bus.cur_floor) req_here_d = 1'b1;
      end
    end
    req_any_d = |pending_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_q       <= '0;
      pending_q     <= '0;
      req_up_q      <= 1'b0;
      req_down_q    <= 1'b0;
      req_here_q    <= 1'b0;
      req_any_q     <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset with the rest.
      for (int i = 0; i < FLOORS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q       <= bus.btn_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      press_q       <= stable_q & ~stable_prev_q;
      pending_q     <= pending_d;
      req_up_q      <= req_up_d;
      req_down_q    <= req_down_d;
      req_here_q    <= req_here_d;
      req_any_q     <= req_any_d;
      for (int i = 0; i < FLOORS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.pending  = pending_q;
  assign bus.req_up   = req_up_q;
  assign bus.req_down = req_down_q;
  assign bus.req_here = req_here_q;
  assign bus.req_any  = req_any_q;

endmodule

// File: tb/tb_call_request_unit.sv
// Directed bench for call_request_unit (FLOORS=4, DEBOUNCE_CYCLES=4, press latency 7 edges).
module tb_call_request_unit;

  typedef struct {
    string      name;
    logic [3:0] btn;
    logic [1:0] cur;
    logic       sv;
    logic [1:0] sf;
    int         adv;
    logic [3:0] exp_pend;
    logic [3:0] exp_req;   // {up, down, here, any}
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  call_request_unit_if #(.FLOORS(4), .FLOOR_W(2)) bus ();

  call_request_unit #(
    .FLOORS          (4),
    .FLOOR_W         (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] pend, input logic [3:0] req);
    check({name, ".pending"}, 32'(bus.pending), 32'(pend));
    check({name, ".req"}, 32'({bus.req_up, bus.req_down, bus.req_here, bus.req_any}), 32'(req));
  endtask

  task automatic drive(input logic [3:0] btn, input logic [1:0] cur, input logic sv,
                       input logic [1:0] sf);
    bus.btn_raw   = btn;
    bus.cur_floor = cur;
    bus.svc_valid = sv;
    bus.svc_floor = sf;
  endtask

  task automatic add(input string name, input logic [3:0] btn, input logic [1:0] cur,
                     input logic sv, input logic [1:0] sf, input int adv,
                     input logic [3:0] pend, input logic [3:0] req);
    vec_t v;
    v.name = name; v.btn = btn; v.cur = cur; v.sv = sv; v.sf = sf;
    v.adv = adv; v.exp_pend = pend; v.exp_req = req;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //   name            btn      cur   sv    sf     adv pending  {u,d,h,a}
    add("call_pre",      4'b1000, 2'd1, 1'b0, 2'd0,  7, 4'b0000, 4'b0000);
    add("call_edge7",    4'b1000, 2'd1, 1'b0, 2'd0,  1, 4'b1000, 4'b0000);
    add("call_edge8",    4'b1000, 2'd1, 1'b0, 2'd0,  1, 4'b1000, 4'b1001);
    add("call_hold",     4'b1000, 2'd1, 1'b0, 2'd0,  1, 4'b1000, 4'b1001);
    add("svc3",          4'b0000, 2'd1, 1'b1, 2'd3,  1, 4'b0000, 4'b1001);
    add("svc3_req",      4'b0000, 2'd1, 1'b0, 2'd0,  1, 4'b0000, 4'b0000);
    add("release_idle",  4'b0000, 2'd1, 1'b0, 2'd0, 10, 4'b0000, 4'b0000);
    add("dir_press",     4'b1001, 2'd0, 1'b0, 2'd0,  8, 4'b1001, 4'b0000);
    add("dir_f0",        4'b0000, 2'd0, 1'b0, 2'd0,  1, 4'b1001, 4'b1011);
    add("dir_f1",        4'b0000, 2'd1, 1'b0, 2'd0,  1, 4'b1001, 4'b1101);
    add("dir_f2",        4'b0000, 2'd2, 1'b0, 2'd0,  1, 4'b1001, 4'b1101);
    add("dir_f3",        4'b0000, 2'd3, 1'b0, 2'd0,  1, 4'b1001, 4'b0111);
    add("dir_f0_same",   4'b0000, 2'd0, 1'b0, 2'd0,  0, 4'b1001, 4'b0111);
    add("dir_f0_next",   4'b0000, 2'd0, 1'b0, 2'd0,  1, 4'b1001, 4'b1011);
    add("clr0",          4'b0000, 2'd0, 1'b1, 2'd0,  1, 4'b1000, 4'b1011);
    add("clr3",          4'b0000, 2'd0, 1'b1, 2'd3,  1, 4'b0000, 4'b1001);
    add("clr_done",      4'b0000, 2'd0, 1'b0, 2'd0,  1, 4'b0000, 4'b0000);
    add("clr_idle",      4'b0000, 2'd0, 1'b0, 2'd0, 10, 4'b0000, 4'b0000);
    add("glitch_on",     4'b0100, 2'd0, 1'b0, 2'd0,  3, 4'b0000, 4'b0000);
    add("glitch_off",    4'b0000, 2'd0, 1'b0, 2'd0, 20, 4'b0000, 4'b0000);

    // Power-on reset.
    rst = 1'b0;
    drive(4'b0000, 2'd1, 1'b0, 2'd0);
    step(3);
    check_outs("reset_init", 4'b0000, 4'b0000);
    rst = 1'b1;
    step(3);

    foreach (vecs[i]) begin
      drive(vecs[i].btn, vecs[i].cur, vecs[i].sv, vecs[i].sf);
      step(vecs[i].adv);
      check_outs(vecs[i].name, vecs[i].exp_pend, vecs[i].exp_req);
    end

    // Press on floor 0 matures in the same cycle floor 0 is serviced: clear wins.
    drive(4'b0001, 2'd0, 1'b0, 2'd0);
    step(7);
    drive(4'b0001, 2'd0, 1'b1, 2'd0);
    step(1);
    drive(4'b0001, 2'd0, 1'b0, 2'd0);
    check("simul_clear_wins", 32'(bus.pending), 32'h0);
    step(6);
    check("held_after_svc", 32'(bus.pending), 32'h0);
    drive(4'b0000, 2'd0, 1'b0, 2'd0);
    step(10);

    // Floor 2 serviced while floor 1 press matures: independent bits.
    drive(4'b0100, 2'd0, 1'b0, 2'd0);
    step(8);
    check("simul_setup", 32'(bus.pending), 32'h4);
    drive(4'b0010, 2'd0, 1'b0, 2'd0);
    step(7);
    drive(4'b0010, 2'd0, 1'b1, 2'd2);
    step(1);
    drive(4'b0010, 2'd0, 1'b0, 2'd0);
    check("simul_independent", 32'(bus.pending), 32'h2);
    drive(4'b0000, 2'd0, 1'b1, 2'd1);
    step(1);
    drive(4'b0000, 2'd0, 1'b0, 2'd0);
    step(10);
    check("simul_cleanup", 32'(bus.pending), 32'h0);

    // Re-press of an already pending floor.
    drive(4'b0100, 2'd0, 1'b0, 2'd0);
    step(8);
    check("repress_setup", 32'(bus.pending), 32'h4);
    drive(4'b0000, 2'd0, 1'b0, 2'd0);
    step(10);
    drive(4'b0100, 2'd0, 1'b0, 2'd0);
    step(10);
`ifdef CALL_CANCEL_EN
    check("repress_cancel", 32'(bus.pending), 32'h0);
`else
    check("repress_noop", 32'(bus.pending), 32'h4);
`endif
    drive(4'b0000, 2'd0, 1'b0, 2'd0);
    step(10);
    drive(4'b0000, 2'd0, 1'b1, 2'd2);
    step(1);
    drive(4'b0000, 2'd0, 1'b0, 2'd0);
    step(2);
    check("repress_cleanup", 32'(bus.pending), 32'h0);

    // Asynchronous reset mid-run with all buttons held, then re-press after release.
    drive(4'b1111, 2'd0, 1'b0, 2'd0);
    step(9);
    check_outs("pre_reset", 4'b1111, 4'b1011);
    #2 rst = 1'b0;
    #1;
    check_outs("async_reset", 4'b0000, 4'b0000);
    step(2);
    rst = 1'b1;
    step(7);
    check_outs("rel_edge6", 4'b0000, 4'b0000);
    step(1);
    check_outs("rel_edge7", 4'b1111, 4'b0000);
    step(1);
    check_outs("rel_edge8", 4'b1111, 4'b1011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_request_unit.md
Name: call_request_unit

Overview:
- Upstream stage of the elevator controller state machine.
- Synchronizes and debounces raw per-floor call buttons, then latches each press as a pending call.
- Clears a pending call when the controller reports that floor serviced.
- Presents registered above/below/here summaries relative to the current floor; these drive the controller's direction inputs.

Parameters:
FLOORS, 4, number of floors / call buttons (2..16)
FLOOR_W, 2, width of floor index; must satisfy 2**FLOOR_W >= FLOORS
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
btn_raw  input  FLOORS  raw asynchronous call buttons, 1 = pressed, bit i = floor i
cur_floor  input  FLOOR_W  current cabin floor from controller
svc_valid  input  1  one-cycle pulse: floor svc_floor has been serviced
svc_floor  input  FLOOR_W  floor being serviced, qualified by svc_valid
pending  output  FLOORS  latched outstanding calls
req_up  output  1  some pending floor > cur_floor
req_down  output  1  some pending floor < cur_floor
req_here  output  1  pending[cur_floor] set
req_any  output  1  OR of pending

Behaviour:
- Design decisions:
  - One clock (clk). rst is asynchronous, active-low.
  - Every flop clears immediately on rst = 0: sync stages, stable levels, debounce counters, pending, and all req_* outputs go to 0.
- Synchronizer:
  - Each btn_raw bit passes through two flops (s1, s2).
- Debounce, per bit:
  - Per-bit counter of width ceil(log2(DEBOUNCE_CYCLES)) and a stable level.
  - If s2 == stable, the counter resets to 0.
  - Otherwise the counter increments.
  - When s2 != stable and counter == DEBOUNCE_CYCLES-1, stable <= s2 and the counter resets.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles at s2 is rejected.
- Press event:
  - A press is a rising edge of stable (0 to 1) for a bit.
  - Only rising edges matter; release has no effect on pending.
- Pending update, per floor i, each cycle:
  - Clear if svc_valid and svc_floor == i.
  - Otherwise set if a press event occurs.
  - Otherwise hold.
  - Same-cycle press and service of the same floor: clear wins.
  - svc_floor >= FLOORS with svc_valid = 1 is ignored; no bit changes.
- Latency:
  - Define edge 0 as the first clk edge sampling the new btn_raw level, held steady.
  - pending bit rises at edge DEBOUNCE_CYCLES+3.
  - req_* reflect it one cycle later.
- Summary outputs:
  - Registered from the current pending register and current cur_floor.
  - Updated every cycle.
  - Latency is one cycle from any change of pending or cur_floor.
  - cur_floor >= FLOORS: req_here = 0, and req_down = req_any.
- Boundaries:
  - cur_floor = 0 gives req_down = 0.
  - cur_floor = FLOORS-1 gives req_up = 0.
- Button held across reset deassertion:
  - stable restarts at 0, so the held button is debounced and registers as a fresh press.
- Button held continuously after its call is serviced:
  - Produces no new call until it is released (debounced) and pressed again.
- Multiple floors may be pressed or serviced in the same cycle, independently.

Optional Feature:
- Macro: CALL_CANCEL_EN.
- Defined:
  - A press event on floor i while pending[i] = 1 and not being serviced toggles pending[i] to 0 (passenger cancels the call).
  - Service clear still has priority.
- Undefined:
  - A press on an already-pending floor is a no-op; pending stays 1.
  - No cancel logic is synthesized.

Test Plan (FLOORS=4, FLOOR_W=2, DEBOUNCE_CYCLES=4, so press latency = 7 edges):
- Reset: rst=0 with btn_raw=4'b1111 mid-run -> pending=0 and all req_*=0 immediately (asynchronously). Release rst with buttons still held -> pending=4'b1111 at edge 7 after release, req_any=1 at edge 8.
- Single call: cur_floor=1; btn_raw[3]=1 for 10 cycles then 0 -> pending=4'b1000 at edge 7, req_up=1, req_down=0, req_here=0 at edge 8. Then svc_valid=1, svc_floor=3 for one cycle -> pending=0 next edge, req_up=0 one edge later.
- Glitch rejection: btn_raw[2] pulsed high for 3 cycles -> pending stays 0 for 20 cycles.
- Simultaneous: press on floor 0 matures in the same cycle as svc_valid=1, svc_floor=0 -> pending[0]=0. Also svc_floor=2 pulsed while pending=4'b0100 and floor 1 press matures -> pending=4'b0010.
- Direction summary: pending=4'b1001, sweep cur_floor 0..3 -> (req_up,req_down,req_here) = 101, 110, 110, 011, each one cycle after the cur_floor change.
- CALL_CANCEL_EN defined: floor 2 pending; release button, then press again for 10 cycles -> pending[2]=0. Same sequence without the macro -> pending[2] stays 1.
